// File: rtl/stage3_hash_arbiter.sv
// Purpose : round-robin scheduler feeding insert/search pulses into the stage-3
//           count-min hash stage, with read-after-write hazard blocking.
// Latency : grant (ready_o high) in cycle g, insert_o/search_o pulse in cycle g+1.
// Backpr. : ready_o is combinational; requests stay pending while a same-key
//           insert is still inside the hazard window.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   ins_*_i / ins_ready_o  insert request channel (valid/ready)
//   srch_*_i / srch_ready_o search request channel (valid/ready)
//   srch_freq_o/_valid_o  registered search result and its one-cycle pulse
//   insert_*_o, search_*_o issue pulses and registered payload to the hash stage
//   insert_end_i, search_end_i, search_freq_i  completion pulses from the hash stage
//   inflight_o            issued-but-not-ended count (0..7, saturating)
//   busy_o                work outstanding or requested
//
// Build option: define STAGE3_ARB_STRICT_EN to make any recent insert block
// every request regardless of key (guards against CRC collisions between
// distinct keys).
module stage3_hash_arbiter #(
  parameter int DW       = 64,
  parameter int HZ_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ins_valid_i,
  output logic          ins_ready_o,
  input  logic [DW-1:0] ins_data_i,
  input  logic [DW-1:0] ins_latency_i,
  input  logic          srch_valid_i,
  output logic          srch_ready_o,
  input  logic [DW-1:0] srch_data_i,
  input  logic [DW-1:0] srch_latency_i,
  output logic [DW-1:0] srch_freq_o,
  output logic          srch_freq_valid_o,
  output logic          insert_o,
  output logic [DW-1:0] insert_data_o,
  output logic [DW-1:0] insert_latency_o,
  input  logic          insert_end_i,
  output logic          search_o,
  output logic [DW-1:0] search_data_o,
  output logic [DW-1:0] search_latency_o,
  input  logic [DW-1:0] search_freq_i,
  input  logic          search_end_i,
  output logic [2:0]    inflight_o,
  output logic          busy_o
);

  localparam int HW = DW / 2;

  typedef struct packed {
    logic          vld;
    logic          is_ins;
    logic [DW-1:0] key;
  } hz_t;

  // hz_q[0] mirrors the op on the output registers; hz_q[k] was issued k cycles ago.
  hz_t [HZ_DEPTH-1:0] hz_q, hz_d;

  logic          prio_ins_q;
  logic          insert_q, search_q;
  logic [DW-1:0] insert_data_q, insert_lat_q;
  logic [DW-1:0] search_data_q, search_lat_q;
  logic [DW-1:0] srch_freq_q;
  logic          srch_freq_vld_q;
  logic [2:0]    inflight_q, inflight_d;

  logic [DW-1:0] ins_key, srch_key;
  logic          ins_blk, srch_blk;
  logic          ins_elig, srch_elig;
  logic          gnt_ins, gnt_srch, gnt_any;

  // Same key layout the hash stage feeds into its CRCs.
  assign ins_key  = {ins_data_i[HW-1:0],  ins_latency_i[HW-1:0]};
  assign srch_key = {srch_data_i[HW-1:0], srch_latency_i[HW-1:0]};

  always_comb begin
    ins_blk  = 1'b0;
    srch_blk = 1'b0;
    for (int k = 0; k < HZ_DEPTH; k++) begin
      if (hz_q[k].vld && hz_q[k].is_ins) begin
`ifdef STAGE3_ARB_STRICT_EN
        ins_blk  = 1'b1;
        srch_blk = 1'b1;
`else
        if (hz_q[k].key == ins_key)  ins_blk  = 1'b1;
        if (hz_q[k].key == srch_key) srch_blk = 1'b1;
`endif
      end
    end
  end

  // No grants while reset is held so ready_o reads 0 like every other output.
  assign ins_elig  = ins_valid_i  & ~ins_blk  & ~rst;
  assign srch_elig = srch_valid_i & ~srch_blk & ~rst;
  assign gnt_ins   = ins_elig & (~srch_elig | prio_ins_q);
  assign gnt_srch  = srch_elig & ~gnt_ins;
  assign gnt_any   = gnt_ins | gnt_srch;

  always_comb begin
    hz_d[0].vld    = gnt_any;
    hz_d[0].is_ins = gnt_ins;
    hz_d[0].key    = gnt_ins ? ins_key : (gnt_srch ? srch_key : '0);
    for (int k = 1; k < HZ_DEPTH; k++) begin
      hz_d[k] = hz_q[k-1];
    end
  end

  // End pulses can only retire ops already counted, so an end seen at zero
  // (e.g. left over from before a reset) is dropped; the new issue is added
  // afterwards and the total saturates at 7.
  logic [1:0] ends;
  logic [2:0] dec;
  logic [3:0] sum;

  always_comb begin
    ends       = {1'b0, insert_end_i} + {1'b0, search_end_i};
    dec        = ({1'b0, ends} > inflight_q) ? inflight_q : {1'b0, ends};
    sum        = {1'b0, inflight_q - dec} + {3'b000, gnt_any};
    inflight_d = sum[3] ? 3'd7 : sum[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_q            <= '0;
      prio_ins_q      <= 1'b1;
      insert_q        <= 1'b0;
      insert_data_q   <= '0;
      insert_lat_q    <= '0;
      search_q        <= 1'b0;
      search_data_q   <= '0;
      search_lat_q    <= '0;
      srch_freq_q     <= '0;
      srch_freq_vld_q <= 1'b0;
      inflight_q      <= '0;
    end else begin
      hz_q          <= hz_d;
      if (gnt_any) prio_ins_q <= gnt_srch;
      insert_q      <= gnt_ins;
      insert_data_q <= gnt_ins ? ins_data_i    : '0;
      insert_lat_q  <= gnt_ins ? ins_latency_i : '0;
      search_q      <= gnt_srch;
      search_data_q <= gnt_srch ? srch_data_i    : '0;
      search_lat_q  <= gnt_srch ? srch_latency_i : '0;
      if (search_end_i) srch_freq_q <= search_freq_i;
      srch_freq_vld_q <= search_end_i;
      inflight_q      <= inflight_d;
    end
  end

  assign ins_ready_o       = gnt_ins;
  assign srch_ready_o      = gnt_srch;
  assign insert_o          = insert_q;
  assign insert_data_o     = insert_data_q;
  assign insert_latency_o  = insert_lat_q;
  assign search_o          = search_q;
  assign search_data_o     = search_data_q;
  assign search_latency_o  = search_lat_q;
  assign srch_freq_o       = srch_freq_q;
  assign srch_freq_valid_o = srch_freq_vld_q;
  assign inflight_o        = inflight_q;
  assign busy_o            = ~rst & ((inflight_q != 3'd0) | ins_valid_i | srch_valid_i);

endmodule
